// File: rtl/fp_align.sv
// fp_align: two-stage IEEE-754 single-precision pre-add alignment (unpack/compare, then sticky shift).
// Optional feature: define FP_ALIGN_SUBNORM_EN to keep subnormal mantissas; otherwise exp==0 flushes to zero.

module fp_unpack #(
  parameter int EW = 8,
  parameter int MW = 23
) (
  input  logic [EW+MW:0]   op,
  output logic             sign,
  output logic [EW+MW-1:0] key,
  output logic [EW-1:0]    eexp,
  output logic [MW:0]      sig,
  output logic             nan,
  output logic             inf
);
  logic [EW-1:0] e;
  logic [MW-1:0] m;

  assign e = op[EW+MW-1:MW];
`ifdef FP_ALIGN_SUBNORM_EN
  assign m = op[MW-1:0];
`else
  assign m = (e == '0) ? '0 : op[MW-1:0];
`endif

  assign sign = op[EW+MW];
  assign key  = {e, m};
  // exp 0 shares the scale of exp 1, only the hidden bit differs
  assign eexp = (e == '0) ? {{(EW-1){1'b0}}, 1'b1} : e;
  assign sig  = {(e != '0), m};
  assign nan  = (&e) &  (|op[MW-1:0]);
  assign inf  = (&e) & ~(|op[MW-1:0]);
endmodule

module fp_align #(
  parameter int N  = 32,
  parameter int EW = 8,
  parameter int MW = 23
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  A,
  input  logic [N-1:0]  B,
  input  logic          in_valid,
  output logic          in_ready,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          big_sign,
  output logic          small_sign,
  output logic [EW-1:0] exp_out,
  output logic [MW:0]   big_mant,
  output logic [MW+3:0] small_mant,
  output logic          eff_sub,
  output logic          is_nan,
  output logic          is_inf
);
  localparam int NUM_OPS = 2;
  localparam int STAGES  = 2;
  localparam int SW      = MW + 4;

  typedef struct packed {
    logic          bs;
    logic          ss;
    logic [EW-1:0] e;
    logic [MW:0]   bm;
    logic [MW:0]   sg;
    logic [EW-1:0] d;
    logic          nan;
    logic          inf;
  } s1_t;

  typedef struct packed {
    logic          bs;
    logic          ss;
    logic [EW-1:0] e;
    logic [MW:0]   bm;
    logic [SW-1:0] sm;
    logic          es;
    logic          nan;
    logic          inf;
  } s2_t;

  logic [NUM_OPS-1:0][N-1:0]     ops;
  logic [NUM_OPS-1:0]            sgn, nan, inf;
  logic [NUM_OPS-1:0][EW+MW-1:0] key;
  logic [NUM_OPS-1:0][EW-1:0]    eexp;
  logic [NUM_OPS-1:0][MW:0]      sig;

  assign ops = {B, A};

  for (genvar i = 0; i < NUM_OPS; i++) begin : g_lane
    fp_unpack #(.EW(EW), .MW(MW)) u_unp (
      .op   (ops[i]),
      .sign (sgn[i]),
      .key  (key[i]),
      .eexp (eexp[i]),
      .sig  (sig[i]),
      .nan  (nan[i]),
      .inf  (inf[i])
    );
  end

  logic [STAGES:1] vld_pipe;
  logic            s2_adv, in_fire;
  s1_t             s1, s1_n;
  s2_t             s2, s2_n;
  logic            bi, si;

  assign s2_adv   = !vld_pipe[2] || out_ready;
  assign in_ready = !vld_pipe[1] || s2_adv;
  assign in_fire  = in_valid && in_ready;

  // ties keep A as the big operand; an infinity always out-ranks a finite value
  assign si = (key[0] >= key[1]);
  assign bi = ~si;

  always_comb begin
    s1_n     = '0;
    s1_n.bs  = sgn[bi];
    s1_n.ss  = sgn[si];
    s1_n.e   = eexp[bi];
    s1_n.bm  = sig[bi];
    s1_n.sg  = sig[si];
    s1_n.d   = eexp[bi] - eexp[si];
    s1_n.nan = (|nan) | ((&inf) & (sgn[0] ^ sgn[1]));
    s1_n.inf = (|inf) & ~s1_n.nan;
  end

  logic [SW-1:0] ext, sh, mask;

  always_comb begin
    ext  = {s1.sg, 3'b000};
    sh   = ext >> s1.d;
    mask = ~({SW{1'b1}} << s1.d);
    s2_n     = '0;
    s2_n.bs  = s1.bs;
    s2_n.ss  = s1.ss;
    s2_n.e   = s1.e;
    s2_n.bm  = s1.bm;
    s2_n.es  = s1.bs ^ s1.ss;
    s2_n.nan = s1.nan;
    s2_n.inf = s1.inf;
    // everything shifted past the S position collapses into the sticky bit
    if (32'(s1.d) >= SW)
      s2_n.sm = {{(SW-1){1'b0}}, |s1.sg};
    else
      s2_n.sm = sh | {{(SW-1){1'b0}}, |(ext & mask)};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      s1       <= '0;
      s2       <= '0;
    end else begin
      vld_pipe[1] <= in_fire | (vld_pipe[1] & ~s2_adv);
      if (s2_adv) vld_pipe[2] <= vld_pipe[1];
      if (in_fire) s1 <= s1_n;
      if (s2_adv && vld_pipe[1]) s2 <= s2_n;
    end
  end

  assign out_valid  = vld_pipe[2];
  assign big_sign   = s2.bs;
  assign small_sign = s2.ss;
  assign exp_out    = s2.e;
  assign big_mant   = s2.bm;
  assign small_mant = s2.sm;
  assign eff_sub    = s2.es;
  assign is_nan     = s2.nan;
  assign is_inf     = s2.inf;
endmodule

// File: tb/tb_fp_align.sv
// Bench for fp_align: behavioural model scoreboard plus literal expectations and handshake checks.
module tb_fp_align;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic [31:0] A = '0, B = '0;
  logic        in_valid = 1'b0, out_ready = 1'b0;
  logic        in_ready, out_valid, big_sign, small_sign, eff_sub, is_nan, is_inf;
  logic [7:0]  exp_out;
  logic [23:0] big_mant;
  logic [26:0] small_mant;

  always #5 clk = ~clk;

  fp_align dut (
    .clk(clk), .rst_n(rst_n), .A(A), .B(B), .in_valid(in_valid), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready), .big_sign(big_sign), .small_sign(small_sign),
    .exp_out(exp_out), .big_mant(big_mant), .small_mant(small_mant), .eff_sub(eff_sub),
    .is_nan(is_nan), .is_inf(is_inf)
  );

  typedef struct packed {
    logic        bs;
    logic        ss;
    logic [7:0]  e;
    logic [23:0] bm;
    logic [26:0] sm;
    logic        es;
    logic        nan;
    logic        inf;
  } res_t;

  typedef struct {
    res_t  m;
    bit    has_lit;
    res_t  lit;
    string nm;
  } sb_t;

  res_t  dut_r;
  sb_t   q[$];
  sb_t   ent;
  int    npass = 0, ntot = 0;
  logic  ck_ov_en = 0, ck_ov = 0, ck_ir_en = 0, ck_ir = 0, ck_zero = 0, ck_drain = 0;
  bit    cur_has_lit = 0;
  res_t  cur_lit = '0;
  string cur_nm = "";

  assign dut_r = {big_sign, small_sign, exp_out, big_mant, small_mant, eff_sub, is_nan, is_inf};

  function automatic res_t mk(input logic bs, ss, input logic [7:0] e, input logic [23:0] bm,
                              input logic [26:0] sm, input logic es, nan, inf);
    res_t r;
    r = {bs, ss, e, bm, sm, es, nan, inf};
    return r;
  endfunction

  // Straight from the number format: pick the larger magnitude, scale the other down, keep sticky.
  function automatic res_t model(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] op [2];
    longint      e [2], m [2], mag [2];
    bit          nn [2], nf [2];
    int          bi, si;
    longint      eb, es_, d, sig_s, v, sm;
    res_t        r;
    op[0] = a; op[1] = b;
    for (int i = 0; i < 2; i++) begin
      e[i] = longint'(op[i][30:23]);
      m[i] = longint'(op[i][22:0]);
`ifndef FP_ALIGN_SUBNORM_EN
      if (e[i] == 0) m[i] = 0;
`endif
      mag[i] = e[i] * 64'd8388608 + m[i];
      nn[i]  = (e[i] == 255) && (op[i][22:0] != 0);
      nf[i]  = (e[i] == 255) && (op[i][22:0] == 0);
    end
    bi    = (mag[1] > mag[0]) ? 1 : 0;
    si    = 1 - bi;
    eb    = (e[bi] == 0) ? 1 : e[bi];
    es_   = (e[si] == 0) ? 1 : e[si];
    d     = eb - es_;
    sig_s = ((e[si] != 0) ? 64'd8388608 : 64'd0) + m[si];
    v     = sig_s * 8;
    if (d >= 27) sm = (sig_s != 0) ? 1 : 0;
    else begin
      sm = v >> d;
      if ((v % (64'd1 << d)) != 0) sm = sm | 1;
    end
    r.bs  = op[bi][31];
    r.ss  = op[si][31];
    r.e   = 8'(eb);
    r.bm  = 24'(((e[bi] != 0) ? 64'd8388608 : 64'd0) + m[bi]);
    r.sm  = 27'(sm);
    r.es  = r.bs ^ r.ss;
    r.nan = nn[0] | nn[1] | (nf[0] && nf[1] && (op[0][31] != op[1][31]));
    r.inf = (nf[0] | nf[1]) && !r.nan;
    return r;
  endfunction

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
  endfunction

  // single compare process: protocol expectations, model scoreboard, literal pins
  always @(negedge clk) begin
    if (ck_ov_en) chk("out_valid", 64'(out_valid), 64'(ck_ov));
    if (ck_ir_en) chk("in_ready", 64'(in_ready), 64'(ck_ir));
    if (ck_zero)  chk("reset_outputs", 64'(dut_r), 64'd0);
    if (ck_drain) chk("scoreboard_empty", 64'(q.size()), 64'd0);
    if (!rst_n) q.delete();
    else begin
      if (out_valid) begin
        if (q.size() == 0) chk("unexpected_output", 64'(out_valid), 64'd0);
        else begin
          chk("model", 64'(dut_r), 64'(q[0].m));
          if (q[0].has_lit) chk(q[0].nm, 64'(dut_r), 64'(q[0].lit));
          if (out_ready) void'(q.pop_front());
        end
      end
      if (in_valid && in_ready) begin
        ent.m = model(A, B); ent.has_lit = cur_has_lit; ent.lit = cur_lit; ent.nm = cur_nm;
        q.push_back(ent);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] a, input logic [31:0] b);
    A = a; B = b; in_valid = 1'b1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk); #1;
        in_valid = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    $display("FAIL send_timeout: in_ready stuck low, got 0 expected 1");
    $fatal(1);
  endtask

  task automatic dsend(input logic [31:0] a, input logic [31:0] b, input res_t lit, input string nm);
    cur_lit = lit; cur_nm = nm; cur_has_lit = 1;
    send(a, b);
    cur_has_lit = 0;
  endtask

  function automatic logic [31:0] rnd_op(input logic [31:0] r);
    logic [31:0] x;
    int          e;
    x = $urandom;
    case ($urandom_range(0, 7))
      3: begin
        e = int'(r[30:23]) + int'($urandom_range(0, 60)) - 30;
        if (e < 0) e = 0;
        if (e > 254) e = 254;
        x[30:23] = 8'(e);
      end
      4: begin
        x[30:23] = 8'hFF;
        if ($urandom_range(0, 1) == 0) x[22:0] = '0;
      end
      5: begin
        x[30:23] = 8'h00;
        if ($urandom_range(0, 2) == 0) x[22:0] = '0;
      end
      6: x[30:0] = r[30:0];
      7: x[30:23] = 8'($urandom_range(1, 2));
      default: ;
    endcase
    return x;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit acc;
    ck_ov_en = 1; ck_ov = 0; ck_ir_en = 1; ck_ir = 1; ck_zero = 1;
    cyc(3);
    rst_n = 1'b1; ck_zero = 0; ck_ir_en = 0; ck_ov_en = 0;
    out_ready = 1'b1;
    cyc(1);

    // d=1 with latency pinned: out_valid low one cycle after transfer, high the next
    dsend(32'h40700000, 32'h40C80000, mk(0, 0, 8'h81, 24'hC80000, 27'h3C00000, 0, 0, 0), "d1");
    ck_ov_en = 1; ck_ov = 0; cyc(1);
    ck_ov = 1; cyc(1);
    ck_ov_en = 0; cyc(2);

    dsend(32'h43160000, 32'h40200000, mk(0, 0, 8'h86, 24'h960000, 27'h0140000, 0, 0, 0), "d6");
    dsend(32'h40080000, 32'hC0080000, mk(0, 1, 8'h80, 24'h880000, 27'h4400000, 1, 0, 0), "tie");
    dsend(32'h3F800000, 32'h30800000, mk(0, 0, 8'h7F, 24'h800000, 27'h0000001, 0, 0, 0), "sticky30");
    dsend(32'h7F800000, 32'hFF800000, mk(0, 1, 8'hFF, 24'h800000, 27'h4000000, 1, 1, 0), "inf_minus_inf");
    dsend(32'h7F800000, 32'h3F800000, mk(0, 0, 8'hFF, 24'h800000, 27'h0000001, 0, 0, 1), "inf_plus_one");
    dsend(32'h3F800000, 32'hFF800000, mk(1, 0, 8'hFF, 24'h800000, 27'h0000001, 1, 0, 1), "inf_is_big");
`ifdef FP_ALIGN_SUBNORM_EN
    dsend(32'h00000001, 32'h00000000, mk(0, 0, 8'h01, 24'h000001, 27'h0, 0, 0, 0), "subnormal");
`else
    dsend(32'h00000001, 32'h00000000, mk(0, 0, 8'h01, 24'h000000, 27'h0, 0, 0, 0), "subnormal_ftz");
`endif
    cyc(3);

    // backpressure: two buffered, third held off until out_ready returns
    out_ready = 1'b0;
    dsend(32'h40700000, 32'h40C80000, mk(0, 0, 8'h81, 24'hC80000, 27'h3C00000, 0, 0, 0), "bp1");
    dsend(32'h43160000, 32'h40200000, mk(0, 0, 8'h86, 24'h960000, 27'h0140000, 0, 0, 0), "bp2");
    cur_lit = mk(0, 1, 8'h80, 24'h880000, 27'h4400000, 1, 0, 0); cur_nm = "bp3"; cur_has_lit = 1;
    A = 32'h40080000; B = 32'hC0080000; in_valid = 1'b1;
    ck_ir_en = 1; ck_ir = 0; ck_ov_en = 1; ck_ov = 1;
    cyc(3);
    out_ready = 1'b1; ck_ir = 1;
    cyc(1);
    in_valid = 1'b0; cur_has_lit = 0; ck_ir_en = 0;
    cyc(2);
    ck_ov = 0; cyc(1);
    ck_ov_en = 0;

    // reset with two pairs in flight: nothing may surface afterwards
    out_ready = 1'b0;
    send(32'h41200000, 32'h40400000);
    send(32'hC1200000, 32'h3F000000);
    rst_n = 1'b0;
    ck_ov_en = 1; ck_ov = 0; ck_ir_en = 1; ck_ir = 1; ck_zero = 1;
    cyc(2);
    rst_n = 1'b1; ck_zero = 0; ck_ir_en = 0; out_ready = 1'b1;
    cyc(4);
    ck_ov_en = 0;

    // randomized traffic with random backpressure, data held until accepted
    acc = 1'b0;
    for (int k = 0; k < 1500; k++) begin
      if (!in_valid || acc) begin
        in_valid = ($urandom_range(0, 9) < 7);
        A = rnd_op($urandom);
        B = rnd_op(A);
      end
      out_ready = ($urandom_range(0, 9) < 7);
      @(negedge clk);
      acc = in_valid && in_ready;
      @(posedge clk); #1;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    cyc(5);
    ck_drain = 1; cyc(1); ck_drain = 0;

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule

// File: doc/fp_align.md
# fp_align

Two-stage pipelined pre-add alignment stage for IEEE-754 single precision, sitting directly upstream of the FP adder core. Accepts operand pairs over a valid/ready handshake and unpacks both operands. It orders them by magnitude and right-shifts the smaller significand by the exponent difference, keeping guard/round/sticky bits. It also flags special cases, so the adder core only performs the significand add/subtract, normalize and round.

## Interface
- `N`, 32, operand width; only 32 supported.
- `EW`, 8, exponent width.
- `MW`, 23, stored mantissa width.

- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `A`  in  N  operand A (IEEE-754).
- `B`  in  N  operand B (IEEE-754).
- `in_valid`  in  1  A/B valid.
- `in_ready`  out  1  stage can accept A/B this cycle.
- `out_valid`  out  1  aligned result valid.
- `out_ready`  in  1  downstream accepts result.
- `big_sign`  out  1  sign of larger-magnitude operand.
- `small_sign`  out  1  sign of smaller-magnitude operand.
- `exp_out`  out  EW  effective exponent of larger operand.
- `big_mant`  out  MW+1  larger significand, hidden bit included.
- `small_mant`  out  MW+4  aligned smaller significand, `{hidden,mant,G,R,S}`.
- `eff_sub`  out  1  `big_sign ^ small_sign`.
- `is_nan`  out  1  result must be quiet NaN.
- `is_inf`  out  1  result is infinity, sign = `big_sign`.

## Operation
- Stage 1 (unpack/compare) registers the following:
  - hidden bit = (exp != 0).
  - Effective exponent = exp, or 1 when exp == 0 (subnormal, see Configuration).
  - Magnitude compare on `{exp,mant}`; A is big when |A| >= |B|, including ties.
  - Difference `d = exp_big - exp_small` (unsigned).
  - Special flags.
- Stage 2 (shift):
  - `small_mant = ({sig_small,3'b000} >> d)`.
  - LSB is ORed with every bit shifted out (sticky).
  - If `d >= MW+4`, `small_mant = {26'b0, |sig_small}`.
- NaN rules: `is_nan`=1 if either operand has exp all-ones and mant != 0, or both are infinities with opposite signs.
- Infinity rules: `is_inf`=1 if either operand is infinite and `is_nan`=0. The infinite operand is selected as big.
- Zero operands need no special case: exp 0, significand 0.
- Handshake:
  - `s2_adv = !s2_valid || out_ready`.
  - `in_ready = !s1_valid || s2_adv`.
  - The input transfers on `in_valid && in_ready`.
  - `out_valid = s2_valid`.
  - `in_ready` depends combinationally on `out_ready`; this path is intended.
- All output data comes from stage-2 registers and is held stable while `out_valid && !out_ready`.
- Order is strictly FIFO; no reordering.

## Timing
- Latency: 2 cycles from input transfer to `out_valid` with no stall. Throughput: 1 pair/cycle.
- Reset (asynchronous, `rst_n`=0):
  - Both stage valids = 0, so `out_valid`=0.
  - All data outputs and flags = 0.
  - `in_ready`=1 one combinational delay after reset assertion.
- Reset mid-stall discards all in-flight pairs. No output is produced for them after release.
- Simultaneous input transfer and output transfer in the same cycle is legal. Stage 1 moves to stage 2 and the new pair enters stage 1.
- With `out_ready` held low: at most 2 pairs are buffered, then `in_ready`=0.

## Configuration
- `FP_ALIGN_SUBNORM_EN` defined: subnormal operands are supported. Exp 0 maps to effective exponent 1 with hidden bit 0, and the mantissa is kept.
- `FP_ALIGN_SUBNORM_EN` undefined: flush-to-zero. Any operand with exp 0 has its mantissa forced to 0, and its sign is kept. Outputs are otherwise identical.

## Test plan
- **Basic alignment, d=1:** A=0x40700000 (3.75), B=0x40C80000 (6.25). Expect big_sign=0, exp_out=0x81, big_mant=0xC80000, small_mant=0x3C00000, eff_sub=0, out_valid exactly 2 cycles after transfer.
- **Alignment, d=6:** A=0x43160000 (150), B=0x40200000 (2.5). Expect exp_out=0x86, big_mant=0x960000, small_mant=0x0140000.
- **Equal magnitudes, opposite sign:** A=0x40080000, B=0xC0080000. Expect A selected (big_sign=0, small_sign=1), eff_sub=1, big_mant=0x880000, small_mant=0x4400000.
- **Sticky and specials:**
  - A=0x3F800000, B=0x30800000 (d=30): expect small_mant=0x0000001.
  - A=0x7F800000, B=0xFF800000: expect is_nan=1.
  - A=0x7F800000, B=0x3F800000: expect is_inf=1, is_nan=0.
- **Backpressure:** out_ready=0 while offering 3 pairs. Expect 2 accepted, in_ready=0 for the third, outputs stable across the stall. Raising out_ready yields all 3 in order, one per cycle.
- **Reset and subnormals:**
  - Assert rst_n low with 2 pairs in flight: expect out_valid=0 immediately, no stale output after release.
  - Subnormal A=0x00000001, B=0x00000000: with macro, big_mant=0x000001, exp_out=1; without macro, big_mant=0.
